// File: rtl/unidad_mult_div_pkg.sv
// rtl/unidad_mult_div_pkg.sv - shared funct codes, FSM encoding and Start decode (divider: MULDIV_DIV_EN)
package unidad_mult_div_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  // Divide codes only count as Start when the divider is built in.
  function automatic logic is_start(input logic rtype, input logic [5:0] funct);
    logic hit;
    hit = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
`ifdef MULDIV_DIV_EN
    hit = hit || (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
`endif
    return rtype && hit;
  endfunction

endpackage

// File: rtl/unidad_mult_div_if.sv
// rtl/unidad_mult_div_if.sv - ID/EX operand bundle and HI/LO/stall results of the mult/div unit
interface unidad_mult_div_if #(
  parameter int NBITS = 32
);
  logic             i_RType;
  logic [5:0]       i_Funct;
  logic [NBITS-1:0] i_Registro1;
  logic [NBITS-1:0] i_Registro2;
  logic             o_Stall;
  logic             o_Busy;
  logic [NBITS-1:0] o_HI;
  logic [NBITS-1:0] o_LO;

  modport master (
    output i_RType, i_Funct, i_Registro1, i_Registro2,
    input  o_Stall, o_Busy, o_HI, o_LO
  );

  modport slave (
    input  i_RType, i_Funct, i_Registro1, i_Registro2,
    output o_Stall, o_Busy, o_HI, o_LO
  );
endinterface

// File: rtl/unidad_mult_div_paso.sv
// rtl/unidad_mult_div_paso.sv - one radix-2 shift-add / restoring-divide step (divide path: MULDIV_DIV_EN)
module unidad_mult_div_paso #(
  parameter int NBITS = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic               op_div,
`endif
  input  logic [2*NBITS-1:0] acc_in,
  input  logic [NBITS-1:0]   oper,
  output logic [2*NBITS-1:0] acc_out
);

  logic [NBITS:0] sum;
`ifdef MULDIV_DIV_EN
  logic [NBITS:0] trial;
  logic [NBITS:0] diff;
`endif

  // Multiply: multiplier sits in the low half and shifts out LSB first; the
  // carry of the add is kept by shifting it into the top bit.
  // Divide: shift remainder:quotient left, keep the subtraction unless it borrows.
  always_comb begin
    sum = {1'b0, acc_in[2*NBITS-1:NBITS]} + {1'b0, oper};
    if (acc_in[0]) begin
      acc_out = {sum, acc_in[NBITS-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[2*NBITS-1:NBITS], acc_in[NBITS-1:1]};
    end
`ifdef MULDIV_DIV_EN
    trial = acc_in[2*NBITS-1:NBITS-1];
    diff  = trial - {1'b0, oper};
    if (op_div) begin
      if (diff[NBITS]) begin
        acc_out = {acc_in[2*NBITS-2:0], 1'b0};
      end else begin
        acc_out = {diff[NBITS-1:0], acc_in[NBITS-2:0], 1'b1};
      end
    end
`endif
  end

endmodule

// File: rtl/unidad_mult_div.sv
// rtl/unidad_mult_div.sv - iterative HI/LO multiply/divide unit with pipeline stall (divider: MULDIV_DIV_EN)
module unidad_mult_div
  import unidad_mult_div_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  unidad_mult_div_if.slave    bus
);

  state_e               state_q, state_d;
  logic [CNTBITS-1:0]   cnt_q, cnt_d;
  logic [2*NBITS-1:0]   acc_q, acc_d;
  logic [NBITS-1:0]     oper_q, oper_d;
  logic                 neg_q, neg_d;
  logic [NBITS-1:0]     hi_q, hi_d;
  logic [NBITS-1:0]     lo_q, lo_d;
`ifdef MULDIV_DIV_EN
  logic                 div_q, div_d;
  logic                 dz_q, dz_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [NBITS-1:0]     rs_q, rs_d;
  logic                 op_is_div;
  logic [NBITS-1:0]     quo_fix;
  logic [NBITS-1:0]     rem_fix;
`endif

  logic                 start;
  logic                 is_signed;
  logic [NBITS-1:0]     rs_abs;
  logic [NBITS-1:0]     rt_abs;
  logic [2*NBITS-1:0]   prod_fix;
  logic [2*NBITS-1:0]   step_acc;

  unidad_mult_div_paso #(.NBITS(NBITS)) u_paso (
`ifdef MULDIV_DIV_EN
    .op_div  (div_q),
`endif
    .acc_in  (acc_q),
    .oper    (oper_q),
    .acc_out (step_acc)
  );

  // Operand decode: Start, magnitudes for signed ops, sign-corrected results.
  always_comb begin
    start     = is_start(bus.i_RType, bus.i_Funct);
    is_signed = (bus.i_Funct == FUNCT_MULT) || (bus.i_Funct == FUNCT_DIV);
    rs_abs    = (is_signed && bus.i_Registro1[NBITS-1]) ? -bus.i_Registro1 : bus.i_Registro1;
    rt_abs    = (is_signed && bus.i_Registro2[NBITS-1]) ? -bus.i_Registro2 : bus.i_Registro2;
    prod_fix  = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    op_is_div = (bus.i_Funct == FUNCT_DIV) || (bus.i_Funct == FUNCT_DIVU);
    quo_fix   = neg_q ? -acc_q[NBITS-1:0] : acc_q[NBITS-1:0];
    rem_fix   = rem_neg_q ? -acc_q[2*NBITS-1:NBITS] : acc_q[2*NBITS-1:NBITS];
`endif
  end

  // Next-state logic: IDLE latches operands, CALC iterates, FIX commits HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    oper_d  = oper_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    div_d     = div_q;
    dz_d      = dz_q;
    rem_neg_d = rem_neg_q;
    rs_d      = rs_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          neg_d   = is_signed && (bus.i_Registro1[NBITS-1] ^ bus.i_Registro2[NBITS-1]);
          acc_d   = {{NBITS{1'b0}}, rt_abs};
          oper_d  = rs_abs;
`ifdef MULDIV_DIV_EN
          div_d     = op_is_div;
          dz_d      = op_is_div && (bus.i_Registro2 == '0);
          rem_neg_d = is_signed && bus.i_Registro1[NBITS-1];
          rs_d      = bus.i_Registro1;
          if (op_is_div) begin
            acc_d  = {{NBITS{1'b0}}, rs_abs};
            oper_d = rt_abs;
          end
`endif
        end else if (bus.i_RType && bus.i_Funct == FUNCT_MTHI) begin
          hi_d = bus.i_Registro1;
        end else if (bus.i_RType && bus.i_Funct == FUNCT_MTLO) begin
          lo_d = bus.i_Registro1;
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTBITS'(NBITS-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          if (dz_q) begin
            hi_d = rs_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
`endif
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      oper_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      rem_neg_q <= 1'b0;
      rs_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      oper_q  <= oper_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
      div_q     <= div_d;
      dz_q      <= dz_d;
      rem_neg_q <= rem_neg_d;
      rs_q      <= rs_d;
`endif
    end
  end

  assign bus.o_Stall = (state_q == IDLE && start) || (state_q == CALC) || (state_q == FIX);
  assign bus.o_Busy  = (state_q == CALC) || (state_q == FIX);
  assign bus.o_HI    = hi_q;
  assign bus.o_LO    = lo_q;

endmodule

// File: tb/tb_unidad_mult_div.sv
// tb/tb_unidad_mult_div.sv - self-checking bench for unidad_mult_div (follows MULDIV_DIV_EN)
module tb_unidad_mult_div;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam int LAT = 34;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  unidad_mult_div_if #(.NBITS(32)) bus ();

  unidad_mult_div #(.NBITS(32), .CNTBITS(5)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic model_start(input logic rt, input logic [5:0] f);
    if (!rt) return 1'b0;
    if (f == 6'h18 || f == 6'h19) return 1'b1;
    if (DIV_ON && (f == 6'h1A || f == 6'h1B)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      6'h18: return 64'(sa * sb);
      6'h19: return ua * ub;
      6'h1A: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      6'h1B: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  // m_t: 0 idle, 1..LAT-1 cycles of work after Start, LAT the release cycle
  int          m_t  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t  <= 0;
      m_hi <= '0;
      m_lo <= '0;
    end else if (m_t == 0) begin
      if (model_start(bus.i_RType, bus.i_Funct)) begin
        m_t <= 1;
        {p_hi, p_lo} <= model_result(bus.i_Funct, bus.i_Registro1, bus.i_Registro2);
      end else if (bus.i_RType && bus.i_Funct == 6'h11) begin
        m_hi <= bus.i_Registro1;
      end else if (bus.i_RType && bus.i_Funct == 6'h13) begin
        m_lo <= bus.i_Registro1;
      end
    end else if (m_t == LAT - 1) begin
      m_t  <= LAT;
      m_hi <= p_hi;
      m_lo <= p_lo;
    end else if (m_t == LAT) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_busy, exp_stall;
      exp_busy  = (m_t >= 1) && (m_t <= LAT - 1);
      exp_stall = exp_busy || (m_t == 0 && model_start(bus.i_RType, bus.i_Funct));
      check("cyc_stall", 32'(bus.o_Stall), 32'(exp_stall));
      check("cyc_busy",  32'(bus.o_Busy),  32'(exp_busy));
      check("cyc_hi",    bus.o_HI, m_hi);
      check("cyc_lo",    bus.o_LO, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nop();
    bus.i_RType     = 1'b0;
    bus.i_Funct     = 6'h00;
    bus.i_Registro1 = '0;
    bus.i_Registro2 = '0;
  endtask

  // Issue an op in IDLE, hold it while stalled; returns at the first unstalled cycle.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    @(posedge clk); #1;
    bus.i_RType     = 1'b1;
    bus.i_Funct     = f;
    bus.i_Registro1 = a;
    bus.i_Registro2 = b;
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.o_Stall) stalls++;
      else break;
    end
  endtask

  task automatic op_check(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_st,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int st;
    run_op(f, a, b, st);
    check({name, "_stalls"}, 32'(st), 32'(exp_st));
    check({name, "_hi"}, bus.o_HI, exp_hi);
    check({name, "_lo"}, bus.o_LO, exp_lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dst;
    logic [31:0] keep_hi, keep_lo;
    nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.o_Stall), 32'h0);
    check("rst_busy",  32'(bus.o_Busy),  32'h0);
    check("rst_hi",    bus.o_HI, 32'h0);
    check("rst_lo",    bus.o_LO, 32'h0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    op_check("mult_7_m3", 6'h18, 32'd7, 32'hFFFF_FFFD, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    op_check("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 32'hFFFF_FFFE, 32'h0000_0001);
    op_check("mult_min2", 6'h18, 32'h8000_0000, 32'h8000_0000, LAT, 32'h4000_0000, 32'h0);
    keep_hi = 32'h4000_0000;
    keep_lo = 32'h0;
    dst = DIV_ON ? LAT : 0;
    op_check("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, dst,
             DIV_ON ? 32'hFFFF_FFFF : keep_hi, DIV_ON ? 32'hFFFF_FFFD : keep_lo);
    op_check("divu_7_2", 6'h1B, 32'd7, 32'd2, dst,
             DIV_ON ? 32'd1 : keep_hi, DIV_ON ? 32'd3 : keep_lo);
    op_check("div_7_m2", 6'h1A, 32'd7, 32'hFFFF_FFFE, dst,
             DIV_ON ? 32'd1 : keep_hi, DIV_ON ? 32'hFFFF_FFFD : keep_lo);
    op_check("divu_5_0", 6'h1B, 32'd5, 32'd0, dst,
             DIV_ON ? 32'd5 : keep_hi, DIV_ON ? 32'hFFFF_FFFF : keep_lo);

    // Asynchronous reset while CALC is at counter 10
    @(posedge clk); #1;
    bus.i_RType     = 1'b1;
    bus.i_Funct     = 6'h18;
    bus.i_Registro1 = 32'd3;
    bus.i_Registro2 = 32'd4;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("calc_busy", 32'(bus.o_Busy), 32'h1);
    rst_n = 1'b0;
    nop();
    #1;
    check("arst_stall", 32'(bus.o_Stall), 32'h0);
    check("arst_busy",  32'(bus.o_Busy),  32'h0);
    check("arst_hi",    bus.o_HI, 32'h0);
    check("arst_lo",    bus.o_LO, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op_check("mult_2_5", 6'h18, 32'd2, 32'd5, LAT, 32'h0, 32'd10);

    // MULT followed directly by MTLO, then MTHI
    op_check("mult_6_7", 6'h18, 32'd6, 32'd7, LAT, 32'h0, 32'd42);
    @(posedge clk); #1;
    bus.i_RType     = 1'b1;
    bus.i_Funct     = 6'h13;
    bus.i_Registro1 = 32'h1234;
    bus.i_Registro2 = 32'h0;
    @(negedge clk);
    check("mtlo_stall", 32'(bus.o_Stall), 32'h0);
    @(posedge clk); #1;
    check("mtlo_lo", bus.o_LO, 32'h1234);
    check("mtlo_hi", bus.o_HI, 32'h0);
    bus.i_Funct     = 6'h11;
    bus.i_Registro1 = 32'hBEEF;
    @(posedge clk); #1;
    check("mthi_hi", bus.o_HI, 32'hBEEF);
    check("mthi_lo", bus.o_LO, 32'h1234);
    nop();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/unidad_mult_div.md
# unidad_mult_div

Iterative HI/LO multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It consumes operands and function code from the ID/EX pipeline register outputs and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. While an operation runs it drives a stall back to the PC, IF/ID and ID/EX registers. It holds the architectural HI/LO registers read by MFHI/MFLO.

## Interface
Parameters:
- NBITS, 32, operand/HI/LO width
- CNTBITS, 5, iteration counter width (2^CNTBITS == NBITS)

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  pipeline clock, rising edge
- i_reset  in  1  asynchronous active-low reset
- i_RType  in  1  ID/EX holds an R-type instruction (ALUOp == 2'b10)
- i_Funct  in  6  ID/EX instruction[5:0]
- i_Registro1  in  NBITS  rs value (multiplicand / dividend / MTHI-MTLO source)
- i_Registro2  in  NBITS  rt value (multiplier / divisor)
- o_Stall  out  1  hold PC, IF/ID, ID/EX; bubble EX/MEM
- o_Busy  out  1  state is CALC or FIX
- o_HI  out  NBITS  HI register
- o_LO  out  NBITS  LO register

## Operation
- Start = i_RType && Funct in {0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU}; evaluated only in IDLE.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: on Start, latch |rs|, |rt| (absolute values for signed ops, raw for unsigned), result sign, op kind, divide-by-zero flag (rt == 0 on DIV/DIVU); counter = 0; go to CALC. MTHI (0x11): HI <= rs; MTLO (0x13): LO <= rs; both single edge, no stall.
  - CALC: one radix-2 step per cycle: shift-add multiply or restoring divide over a 2*NBITS accumulator; counter increments; after counter == NBITS-1, go to FIX.
  - FIX: apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign); write HI/LO at the end of FIX; go to DONE.
  - DONE: stall released so the stalled instruction advances; Start ignored; go to IDLE.
- Divide by zero: HI <= original rs, LO <= all ones, regardless of signedness.
- MULT/MULTU: HI:LO = 2*NBITS product. DIV/DIVU: LO = quotient, HI = remainder, truncating toward zero.
- o_Stall = (state == IDLE && Start) || state == CALC || state == FIX. Combinational from ID/EX outputs; no combinational path from any EX input.
- o_Busy = state in {CALC, FIX}.

## Timing
- Reset (asynchronous, any state, including mid-CALC): state IDLE, HI = 0, LO = 0, counter = 0, accumulator = 0. Result: o_Stall = 0, o_Busy = 0, o_HI = 0, o_LO = 0. Any in-flight operation is discarded.
- Latency: the Start cycle, NBITS CALC cycles and 1 FIX cycle give NBITS+2 = 34 stalled cycles. HI/LO are visible from the DONE cycle onward.
- Back-to-back: a new Start seen in IDLE on the cycle after DONE begins immediately.
- MFHI/MFLO directly following a MULT/DIV reads the correct value; the stall guarantees it.
- MTHI/MTLO in IDLE update on the next edge. Pipeline order prevents a simultaneous Start and MT in the same cycle.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are implemented as above.
- MULDIV_DIV_EN undefined: the divider datapath is removed; 0x1A/0x1B are not Start. No stall occurs and HI/LO are unchanged. MULT/MULTU/MTHI/MTLO are unaffected.

## Structure
- Shared package: funct constants (FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO) and the state encoding (IDLE, CALC, FIX, DONE), reused by the control unit and forwarding logic.
- One sub-module, unidad_mult_div_paso: combinational single-step shift-add/restoring-subtract on the accumulator, selected by op kind. The top level holds the FSM, counter, sign handling and HI/LO.

## Test plan
- MULT rs=7, rt=0xFFFFFFFD (-3) -> o_Stall high exactly 34 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7, rt=2 -> LO=3, HI=1.
- DIVU rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5. Without MULDIV_DIV_EN: no stall, HI/LO unchanged.
- MULT 3*4, then i_reset low for 1 cycle at CALC counter 10 -> o_Stall=0 and HI=LO=0 immediately; a following MULT 2*5 gives LO=10.
- MULT 6*7 immediately followed by MTLO rs=0x1234 -> LO=42 in DONE; LO=0x1234 one edge after MTLO reaches IDLE; HI stays 0.
